// File: rtl/mem_data_lanes_if.sv
// Load/store port bundle for mem_data_lanes: one read request/response path,
// one write path and the clear-in-progress flag.
interface mem_data_lanes_if #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 32
);
    localparam int OFFW = $clog2(WIDTH / 8);

    logic                  busy_o;
    logic                  re_i;
    logic [DEPTH+OFFW-1:0] raddr_i;
    logic [2:0]            rsize_i;
    logic [WIDTH-1:0]      rdata_o;
    logic                  rvalid_o;
    logic                  rerr_o;
    logic                  we_i;
    logic [DEPTH+OFFW-1:0] waddr_i;
    logic [1:0]            wsize_i;
    logic [WIDTH-1:0]      wdata_i;
    logic                  werr_o;

    modport master (
        output re_i, raddr_i, rsize_i, we_i, waddr_i, wsize_i, wdata_i,
        input  busy_o, rdata_o, rvalid_o, rerr_o, werr_o
    );

    modport slave (
        input  re_i, raddr_i, rsize_i, we_i, waddr_i, wsize_i, wdata_i,
        output busy_o, rdata_o, rvalid_o, rerr_o, werr_o
    );
endinterface

// File: rtl/mem_data_lanes.sv
// Byte-lane data memory with RISC-V load/store sizing and a post-reset clear.
// Define MEMDATA_BYPASS_EN to forward a same-word, same-cycle store into the load.
module mem_data_lanes #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_data_lanes_if.slave   bus
);
    localparam int LANES  = WIDTH / 8;
    localparam int OFFW   = $clog2(LANES);
    localparam int NWORDS = 1 << DEPTH;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state_reg, state_next;
    logic [DEPTH-1:0]  cnt_reg, cnt_next;
    logic              busy;

    // Illegal size (doubleword on a 32-bit memory) or offset not a multiple of the size.
    function automatic logic is_bad(input logic [1:0] sz, input logic [OFFW-1:0] off);
        logic [7:0] m8;
        m8 = 8'((1 << sz) - 1);
        return ((WIDTH == 32) && (sz == 2'd3)) || ((8'(off) & m8) != 8'd0);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b0;
        unique case (state_reg)
            CLEAR: begin
                busy     = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == DEPTH'(NWORDS - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                busy = 1'b0;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    logic                  accept;
    logic                  rd_acc;
    logic                  wr_ok;
    logic                  w_bad;
    logic                  r_bad;
    logic [DEPTH-1:0]      r_word;
    logic [DEPTH-1:0]      w_word;
    logic [OFFW-1:0]       r_off;
    logic [OFFW-1:0]       w_off;
    logic [OFFW-1:0]       w_mask;
    logic [7:0]            w_m8;
    logic [15:0]           be16;
    logic [LANES-1:0]      w_be;

    always_comb begin
        accept = !busy && !rst_i;
        r_word = bus.raddr_i[DEPTH+OFFW-1:OFFW];
        r_off  = bus.raddr_i[OFFW-1:0];
        w_word = bus.waddr_i[DEPTH+OFFW-1:OFFW];
        w_off  = bus.waddr_i[OFFW-1:0];
        r_bad  = is_bad(bus.rsize_i[1:0], r_off);
        w_bad  = is_bad(bus.wsize_i, w_off);
        rd_acc = accept && bus.re_i;
        wr_ok  = accept && bus.we_i && !w_bad;
        w_m8   = 8'((1 << bus.wsize_i) - 1);
        w_mask = w_m8[OFFW-1:0];
        be16   = 16'(((1 << (1 << bus.wsize_i)) - 1) << w_off);
        w_be   = be16[LANES-1:0];
    end

    logic [WIDTH-1:0] rd_word;

    // One 8-bit RAM per lane so each byte enable maps onto its own write port.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0]       ram [NWORDS];
        logic [7:0]       q_reg;
        logic [7:0]       wbyte;
        logic [7:0]       lane_din;
        logic [OFFW-1:0]  src;
        logic             lane_we;
        logic [DEPTH-1:0] lane_addr;
        logic [7:0]       rd_lane;

        always_comb begin
            src       = OFFW'(gi) & w_mask;
            wbyte     = bus.wdata_i[{src, 3'b000} +: 8];
            lane_we   = busy || (wr_ok && w_be[gi]);
            lane_addr = busy ? cnt_reg : w_word;
            lane_din  = busy ? 8'h00 : wbyte;
        end

        always_ff @(posedge clk_i) begin
            if (lane_we) begin
                ram[lane_addr] <= lane_din;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                q_reg <= 8'h00;
            end else if (rd_acc) begin
                q_reg <= ram[r_word];
            end
        end

`ifdef MEMDATA_BYPASS_EN
        logic       byp_reg;
        logic [7:0] bdata_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                byp_reg   <= 1'b0;
                bdata_reg <= 8'h00;
            end else if (rd_acc) begin
                byp_reg   <= wr_ok && w_be[gi] && (w_word == r_word);
                bdata_reg <= wbyte;
            end
        end

        assign rd_lane = byp_reg ? bdata_reg : q_reg;
`else
        assign rd_lane = q_reg;
`endif

        assign rd_word[gi*8 +: 8] = rd_lane;
    end

    logic             rvalid_reg;
    logic             rerr_hold_reg;
    logic             werr_reg;
    logic [OFFW-1:0]  roff_reg;
    logic [2:0]       rsize_reg;

    // Offset, size and error are held with the RAM output so rdata stays stable between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_reg    <= 1'b0;
            rerr_hold_reg <= 1'b0;
            werr_reg      <= 1'b0;
            roff_reg      <= '0;
            rsize_reg     <= '0;
        end else begin
            rvalid_reg <= rd_acc;
            werr_reg   <= accept && bus.we_i && w_bad;
            if (rd_acc) begin
                roff_reg      <= r_off;
                rsize_reg     <= bus.rsize_i;
                rerr_hold_reg <= r_bad;
            end
        end
    end

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] keep_mask;
    logic             sbit;
    logic             sgn;
    logic [WIDTH-1:0] rdata;

    always_comb begin
        shifted = rd_word >> {roff_reg, 3'b000};
        unique case (rsize_reg[1:0])
            2'd0: begin
                keep_mask = WIDTH'(8'hFF);
                sbit      = shifted[7];
            end
            2'd1: begin
                keep_mask = WIDTH'(16'hFFFF);
                sbit      = shifted[15];
            end
            2'd2: begin
                keep_mask = WIDTH'(32'hFFFF_FFFF);
                sbit      = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sbit      = 1'b0;
            end
        endcase
        sgn   = !rsize_reg[2] && sbit;
        rdata = rerr_hold_reg ? '0
                              : ((shifted & keep_mask) | ({WIDTH{sgn}} & ~keep_mask));
    end

    assign bus.busy_o   = busy;
    assign bus.rvalid_o = rvalid_reg;
    assign bus.rerr_o   = rvalid_reg && rerr_hold_reg;
    assign bus.rdata_o  = rdata;
    assign bus.werr_o   = werr_reg;
endmodule

// File: tb/tb_mem_data_lanes.sv
// Randomised scoreboard bench for mem_data_lanes against a byte-array memory model.
module tb_mem_data_lanes;
    localparam int DEPTH  = 6;
    localparam int WIDTH  = 32;
    localparam int NBYTES = (1 << DEPTH) * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_data_lanes_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    mem_data_lanes #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mb [NBYTES];

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
        int          addr;
    } rexp_t;

    rexp_t rq[$];
    int    wq[$];

    function automatic logic bad(input logic [1:0] sz, input int addr);
        return (sz == 2'd3) || ((addr % (1 << sz)) != 0);
    endfunction

    function automatic logic [31:0] mread(input int addr, input logic [2:0] sz);
        int          nb;
        logic [31:0] v;
        nb = 1 << sz[1:0];
        v  = 32'h0;
        for (int k = 0; k < nb; k++) v = v | (32'(mb[addr + k]) << (8 * k));
        if (!sz[2] && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic mwrite(input int addr, input logic [1:0] sz, input logic [31:0] d);
        for (int k = 0; k < (1 << sz); k++) mb[addr + k] = d[8 * k +: 8];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    // One clock of stimulus; when track is set the model predicts the response.
    task automatic drive(input logic re, input int ra, input logic [2:0] rs,
                         input logic we, input int wa, input logic [1:0] ws,
                         input logic [31:0] wd, input logic track);
        rexp_t e;
        @(posedge clk);
        #1;
        bus.re_i    = re;
        bus.raddr_i = ra[DEPTH+1:0];
        bus.rsize_i = rs;
        bus.we_i    = we;
        bus.waddr_i = wa[DEPTH+1:0];
        bus.wsize_i = ws;
        bus.wdata_i = wd;
        if (track) begin
`ifdef MEMDATA_BYPASS_EN
            if (we && !bad(ws, wa)) mwrite(wa, ws, wd);
`endif
            if (re) begin
                e.err  = bad(rs[1:0], ra);
                e.data = e.err ? 32'h0 : mread(ra, rs);
                e.due  = cyc + 1;
                e.addr = ra;
                rq.push_back(e);
            end
`ifndef MEMDATA_BYPASS_EN
            if (we && !bad(ws, wa)) mwrite(wa, ws, wd);
`endif
            if (we && bad(ws, wa)) wq.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 3'd0, 1'b0, 0, 2'd0, 32'h0, 1'b1);
    endtask

    task automatic rnd_untracked();
        drive(1'($urandom), int'($urandom_range(0, NBYTES - 1)), 3'($urandom),
              1'($urandom), int'($urandom_range(0, NBYTES - 1)), 2'($urandom),
              $urandom, 1'b0);
    endtask

    task automatic release_and_count(input string name);
        int n;
        n = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        while (bus.busy_o === 1'b1 && n < 300) begin
            n++;
            rnd_untracked();
        end
        bus.re_i = 1'b0;
        bus.we_i = 1'b0;
        chk(name, 32'(n), 32'd64);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        rexp_t e;
        int    d;
        if (bus.rvalid_o === 1'b1) begin
            n_vec++;
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL rvalid_unexpected: got rvalid at cycle %0d, required none", cyc);
            end else begin
                e = rq.pop_front();
                if (bus.rerr_o !== e.err || bus.rdata_o !== e.data || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL read@0x%02h: got err=%0b data=0x%08h cycle=%0d, required err=%0b data=0x%08h cycle=%0d",
                             e.addr, bus.rerr_o, bus.rdata_o, cyc, e.err, e.data, e.due);
                end
            end
        end
        if (bus.werr_o === 1'b1) begin
            n_vec++;
            if (wq.size() == 0) begin
                n_bad++;
                $display("FAIL werr_unexpected: got werr at cycle %0d, required none", cyc);
            end else begin
                d = wq.pop_front();
                if (cyc != d) begin
                    n_bad++;
                    $display("FAIL werr_timing: got cycle %0d, required cycle %0d", cyc, d);
                end
            end
        end
    end

    initial begin
        int ra;
        int wa;
        bus.re_i = 1'b0; bus.raddr_i = '0; bus.rsize_i = '0;
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.wsize_i = '0; bus.wdata_i = '0;
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   32'(bus.busy_o),   32'd1);
        chk("reset_rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("reset_rerr",   32'(bus.rerr_o),   32'd0);
        chk("reset_werr",   32'(bus.werr_o),   32'd0);
        chk("reset_rdata",  bus.rdata_o,       32'h0);
        release_and_count("busy_after_reset");

        for (int w = 0; w < (1 << DEPTH); w++) drive(1'b1, w * 4, 3'd2, 1'b0, 0, 2'd0, 32'h0, 1'b1);

        drive(1'b0, 0, 3'd0, 1'b1, 'h10, 2'd2, 32'h8081_F27F, 1'b1);
        drive(1'b1, 'h10, 3'd0, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b1, 'h11, 3'd0, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b1, 'h13, 3'd4, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b1, 'h12, 3'd1, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b0, 0, 3'd0, 1'b1, 'h20, 2'd2, 32'h1111_1111, 1'b1);
        drive(1'b0, 0, 3'd0, 1'b1, 'h22, 2'd1, 32'h0000_BEEF, 1'b1);
        drive(1'b1, 'h20, 3'd2, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        idle(2);
        drive(1'b1, 'h21, 3'd2, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b0, 0, 3'd0, 1'b1, 'h23, 2'd1, 32'h0000_DEAD, 1'b1);
        drive(1'b1, 'h20, 3'd2, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b0, 0, 3'd0, 1'b1, 'h20, 2'd3, 32'hCAFE_F00D, 1'b1);
        drive(1'b1, 'h20, 3'd2, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b0, 0, 3'd0, 1'b1, 'h30, 2'd2, 32'h1234_5678, 1'b1);
        drive(1'b1, 'h30, 3'd2, 1'b1, 'h30, 2'd0, 32'h0000_00AA, 1'b1);
        drive(1'b1, 'h10, 3'd2, 1'b1, 'h34, 2'd2, 32'h5A5A_A5A5, 1'b1);
        drive(1'b1, 'h34, 3'd6, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            ra = int'($urandom_range(0, NBYTES - 1));
            wa = ($urandom_range(0, 1) == 0) ? ((ra & ~3) | int'($urandom_range(0, 3)))
                                             : int'($urandom_range(0, NBYTES - 1));
            drive(1'($urandom), ra, 3'($urandom), 1'($urandom), wa, 2'($urandom), $urandom, 1'b1);
        end
        idle(3);

        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.re_i = 1'b1;
        bus.raddr_i = '0;
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
        @(posedge clk);
        #1 bus.re_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) rnd_untracked();
        rst = 1'b1;
        bus.we_i = 1'b0;
        bus.re_i = 1'b1;
        bus.raddr_i = 8'h08;
        @(posedge clk);
        #1 bus.re_i = 1'b0;
        release_and_count("busy_after_midclear_rst");

        for (int w = 0; w < 8; w++) drive(1'b1, w * 8, 3'd2, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b0, 0, 3'd0, 1'b1, 'h3C, 2'd2, 32'hF00D_8001, 1'b1);
        drive(1'b1, 'h3E, 3'd1, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        drive(1'b1, 'h3C, 3'd5, 1'b0, 0, 2'd0, 32'h0, 1'b1);
        idle(5);

        chk("reads_outstanding",  32'(rq.size()), 32'd0);
        chk("werrs_outstanding",  32'(wq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
